// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - round-robin scan controller around a 4x1 channel mux
// Optional channel masking is enabled by defining SCAN_MASK_EN.
module mux_scan_ctrl #(
  parameter int N_CH       = 4,
  parameter int SEL_W      = 2,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic             start,
  input  logic             abort,
  input  logic             y,
`ifdef SCAN_MASK_EN
  input  logic [N_CH-1:0]  mask,
`endif
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic [N_CH-1:0]  frame,
  output logic             frame_valid
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic [N_CH-1:0]  r_shadow, r_frame, w_sample;
  logic [N_CH-1:0]  w_mask_src, w_mask_cur;
  logic             r_valid, w_valid_nxt, w_frame_ld, w_zero_ld, w_scan_start;
  logic [SEL_W-1:0] w_first, w_next;
  logic             w_last, w_none;

`ifdef SCAN_MASK_EN
  logic [N_CH-1:0] r_mask;

  // A fresh start looks at the live mask; a continuous restart reuses the held one.
  assign w_mask_src = (r_state == S_IDLE) ? mask : r_mask;
  assign w_mask_cur = r_mask;

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_mask <= '0;
    end else if (r_state == S_IDLE && start && !abort) begin
      r_mask <= mask;
    end
  end
`else
  assign w_mask_src = '1;
  assign w_mask_cur = '1;
`endif

  always_comb begin
    w_first = '0;
    w_none  = 1'b1;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_mask_src[i]) begin
        w_first = SEL_W'(i);
        w_none  = 1'b0;
      end
    end
    w_next = r_sel;
    w_last = 1'b1;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_mask_cur[i] && (SEL_W'(i) > r_sel)) begin
        w_next = SEL_W'(i);
        w_last = 1'b0;
      end
    end
    w_sample        = r_shadow;
    w_sample[r_sel] = y;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_valid_nxt  = 1'b0;
    w_frame_ld   = 1'b0;
    w_zero_ld    = 1'b0;
    w_scan_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_sel_nxt = '0;
        w_scan_start = start && !abort;
      end
      S_SCAN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_sel_nxt   = '0;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
          w_sel_nxt   = '0;
          w_frame_ld  = 1'b1;
          w_valid_nxt = 1'b1;
        end else begin
          w_sel_nxt = w_next;
        end
      end
      S_DONE: begin
        w_sel_nxt    = '0;
        w_state_nxt  = S_IDLE;
        w_scan_start = CONTINUOUS && !abort;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_sel_nxt   = '0;
      end
    endcase
    // An empty mask completes immediately with an all-zero frame.
    if (w_scan_start) begin
      if (w_none) begin
        w_state_nxt = S_DONE;
        w_zero_ld   = 1'b1;
        w_valid_nxt = 1'b1;
      end else begin
        w_state_nxt = S_SCAN;
        w_sel_nxt   = w_first;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_sel    <= '0;
      r_shadow <= '0;
      r_frame  <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_sel   <= w_sel_nxt;
      r_valid <= w_valid_nxt;
      if (r_state == S_SCAN && !abort) begin
        r_shadow <= w_sample;
      end
      if (w_frame_ld) begin
        r_frame <= w_sample & w_mask_cur;
      end else if (w_zero_ld) begin
        r_frame <= '0;
      end
    end
  end

  assign sel         = r_sel;
  assign busy        = (r_state == S_SCAN);
  assign frame       = r_frame;
  assign frame_valid = r_valid;

endmodule
